p_dispatch_gen: RTL

- Parametrised successor to the 2-wide dispatch stage. It takes one rename bundle of DISPATCH_W instructions and holds it in a dispatch register.
- Each lane is steered to one of NUM_IQ issue queues, with independent per-queue handshakes, so partial dispatch is allowed.
- Held source operands keep waking up from the CDB while the bundle is stalled.
- Sits between rename and the issue queues (ALU0, ALU1, MDU, LSU by default).

---
 rtl/p_dispatch_gen_pkg.sv | 33 +++
 rtl/p_dispatch_gen_wakeup.sv | 30 +++
 rtl/p_dispatch_gen.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/p_dispatch_gen_pkg.sv
// Shared types and constants for the parametrised dispatch stage and its bench.
package p_dispatch_gen_pkg;

  localparam int DEF_DISPATCH_W = 2;
  localparam int DEF_SRC_N      = 2;
  localparam int DEF_CDB_W      = 2;
  localparam int DEF_NUM_IQ     = 4;
  localparam int DEF_PREG_W     = 6;
  localparam int DEF_DATA_W     = 32;

  localparam int IQ_ALU0 = 0;
  localparam int IQ_ALU1 = 1;
  localparam int IQ_MDU  = 2;
  localparam int IQ_LSU  = 3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } disp_state_e;

  typedef struct packed {
    logic [DEF_PREG_W-1:0] preg;
    logic [DEF_DATA_W-1:0] data;
    logic                  rdy;
  } p_dispatch_src_t;

  typedef struct packed {
    logic                  valid;
    logic [DEF_PREG_W-1:0] preg;
    logic [DEF_DATA_W-1:0] data;
  } p_dispatch_cdb_t;

endpackage

// File: rtl/p_dispatch_gen_wakeup.sv
// One source operand compared against every CDB port; the lowest-index matching port
// supplies the data and physical register 0 never matches.
module p_dispatch_wakeup
  import p_dispatch_gen_pkg::*;
#(
  parameter int CDB_W  = DEF_CDB_W,
  parameter int PREG_W = DEF_PREG_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [PREG_W-1:0]       src_preg,
  input  logic [CDB_W-1:0]        cdb_valid,
  input  logic [CDB_W*PREG_W-1:0] cdb_preg,
  input  logic [CDB_W*DATA_W-1:0] cdb_data,
  output logic                    hit,
  output logic [DATA_W-1:0]       hit_data
);

  // Scanning from the top down lets the lowest matching port overwrite last.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int k = CDB_W - 1; k >= 0; k--) begin
      if (cdb_valid[k] && (src_preg != '0) && (cdb_preg[k*PREG_W +: PREG_W] == src_preg)) begin
        hit      = 1'b1;
        hit_data = cdb_data[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/p_dispatch_gen.sv
// Dispatch register steering each lane of a rename bundle to its issue queue.
// Optional P_DISPATCH_GEN_PERF_EN adds saturating stall / partial-dispatch counters.
module p_dispatch_gen
  import p_dispatch_gen_pkg::*;
#(
  parameter int DISPATCH_W = DEF_DISPATCH_W,
  parameter int SRC_N      = DEF_SRC_N,
  parameter int CDB_W      = DEF_CDB_W,
  parameter int NUM_IQ     = DEF_NUM_IQ,
  parameter int PREG_W     = DEF_PREG_W,
  parameter int DATA_W     = DEF_DATA_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush_i,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [DISPATCH_W-1:0]               in_lane_valid,
  input  logic [DISPATCH_W*NUM_IQ-1:0]        in_iq_sel,
  input  logic [DISPATCH_W*SRC_N*PREG_W-1:0]  in_src_preg,
  input  logic [DISPATCH_W*SRC_N*DATA_W-1:0]  in_src_data,
  input  logic [DISPATCH_W*SRC_N-1:0]         in_src_rdy,
  input  logic [CDB_W-1:0]                    cdb_valid,
  input  logic [CDB_W*PREG_W-1:0]             cdb_preg,
  input  logic [CDB_W*DATA_W-1:0]             cdb_data,
  output logic [NUM_IQ-1:0]                   iq_valid,
  input  logic [NUM_IQ-1:0]                   iq_ready,
  output logic [NUM_IQ*DISPATCH_W-1:0]        iq_lane_mask,
  output logic [DISPATCH_W*SRC_N*DATA_W-1:0]  iq_src_data,
  output logic [DISPATCH_W*SRC_N-1:0]         iq_src_rdy
`ifdef P_DISPATCH_GEN_PERF_EN
  ,
  output logic [31:0]                         perf_stall_cnt,
  output logic [31:0]                         perf_partial_cnt
`endif
);

  localparam int OPN = DISPATCH_W * SRC_N;

  disp_state_e                  state_q, state_d;
  logic [DISPATCH_W-1:0]        pending_q, pending_d;
  logic [DISPATCH_W*NUM_IQ-1:0] sel_q, sel_d;
  logic [OPN*PREG_W-1:0]        preg_q, preg_d;
  logic [OPN*DATA_W-1:0]        data_q, data_d;
  logic [OPN-1:0]               rdy_q, rdy_d;

  logic [OPN-1:0]               held_hit, in_hit;
  logic [OPN*DATA_W-1:0]        held_hit_data, in_hit_data;
  logic                         hold;
  logic [NUM_IQ-1:0]            fire;
  logic [DISPATCH_W-1:0]        fired;
  logic                         drain;
  logic                         accept;

  for (genvar i = 0; i < OPN; i++) begin : g_wake
    p_dispatch_wakeup #(.CDB_W(CDB_W), .PREG_W(PREG_W), .DATA_W(DATA_W)) u_held (
      .src_preg  (preg_q[i*PREG_W +: PREG_W]),
      .cdb_valid (cdb_valid),
      .cdb_preg  (cdb_preg),
      .cdb_data  (cdb_data),
      .hit       (held_hit[i]),
      .hit_data  (held_hit_data[i*DATA_W +: DATA_W])
    );
    p_dispatch_wakeup #(.CDB_W(CDB_W), .PREG_W(PREG_W), .DATA_W(DATA_W)) u_in (
      .src_preg  (in_src_preg[i*PREG_W +: PREG_W]),
      .cdb_valid (cdb_valid),
      .cdb_preg  (cdb_preg),
      .cdb_data  (cdb_data),
      .hit       (in_hit[i]),
      .hit_data  (in_hit_data[i*DATA_W +: DATA_W])
    );
  end

  // Operands seen by the queues include this cycle's CDB hits so a waking enqueue is ready.
  always_comb begin
    hold        = (state_q == ST_HOLD);
    iq_src_rdy  = '0;
    iq_src_data = '0;
    for (int i = 0; i < OPN; i++) begin
      iq_src_rdy[i] = rdy_q[i] | (hold & held_hit[i]);
      iq_src_data[i*DATA_W +: DATA_W] = (!rdy_q[i] && hold && held_hit[i]) ?
          held_hit_data[i*DATA_W +: DATA_W] : data_q[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    iq_lane_mask = '0;
    iq_valid     = '0;
    fire         = '0;
    fired        = '0;
    for (int q = 0; q < NUM_IQ; q++) begin
      for (int l = 0; l < DISPATCH_W; l++) begin
        iq_lane_mask[q*DISPATCH_W + l] = pending_q[l] & sel_q[l*NUM_IQ + q];
      end
      iq_valid[q] = hold & (|iq_lane_mask[q*DISPATCH_W +: DISPATCH_W]) & ~flush_i & ~rst;
      fire[q]     = iq_valid[q] & iq_ready[q];
      if (fire[q]) begin
        fired = fired | iq_lane_mask[q*DISPATCH_W +: DISPATCH_W];
      end
    end
    drain    = hold & ((pending_q & ~fired) == '0);
    in_ready = (~hold | drain) & ~flush_i & ~rst;
    accept   = in_valid & in_ready;
  end

  // Flush discards everything; an accept replaces the bundle, else fired lanes retire.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q & ~fired;
    sel_d     = sel_q;
    preg_d    = preg_q;
    data_d    = iq_src_data;
    rdy_d     = iq_src_rdy;
    if (flush_i) begin
      state_d   = ST_EMPTY;
      pending_d = '0;
      data_d    = data_q;
      rdy_d     = rdy_q;
    end else if (accept) begin
      state_d   = (|in_lane_valid) ? ST_HOLD : ST_EMPTY;
      pending_d = in_lane_valid;
      sel_d     = in_iq_sel;
      preg_d    = in_src_preg;
      for (int i = 0; i < OPN; i++) begin
        rdy_d[i] = in_src_rdy[i] | in_hit[i];
        data_d[i*DATA_W +: DATA_W] = (!in_src_rdy[i] && in_hit[i]) ?
            in_hit_data[i*DATA_W +: DATA_W] : in_src_data[i*DATA_W +: DATA_W];
      end
    end else if (hold && (pending_d == '0)) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      pending_q <= '0;
      sel_q     <= '0;
      preg_q    <= '0;
      data_q    <= '0;
      rdy_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      sel_q     <= sel_d;
      preg_q    <= preg_d;
      data_q    <= data_d;
      rdy_q     <= rdy_d;
    end
  end

`ifdef P_DISPATCH_GEN_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] partial_cnt_q, partial_cnt_d;

  always_comb begin
    stall_cnt_d   = stall_cnt_q;
    partial_cnt_d = partial_cnt_q;
    if (hold && (fire == '0) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if ((fired != '0) && ((pending_q & ~fired) != '0) && (partial_cnt_q != '1)) begin
      partial_cnt_d = partial_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q   <= '0;
      partial_cnt_q <= '0;
    end else begin
      stall_cnt_q   <= stall_cnt_d;
      partial_cnt_q <= partial_cnt_d;
    end
  end

  assign perf_stall_cnt   = stall_cnt_q;
  assign perf_partial_cnt = partial_cnt_q;
`endif

endmodule
